router_pkt_tx: RTL and testbench

//  Packet source for the 1x3 router input port: buffers payload bytes, then on start drives

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_pkt_tx_if.sv | 34 +++
 rtl/router_tx_fifo.sv | 65 ++++++
 rtl/router_pkt_tx.sv | 136 +++++++++++++
 tb/tb_router_pkt_tx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared widths, tx FSM states and header helper for the
// router packet source and the router RTL itself.
package router_pkg;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;
  localparam int BUF_AW = 6;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_e;

  function automatic logic [DATA_W-1:0] make_header(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction
endpackage

// File: rtl/router_pkt_tx_if.sv
// Bundle of buffer-write, launch and router-side signals
// of the packet source; slave is the source, master its user.
import router_pkg::*;

interface router_pkt_tx_if;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              buf_full;
  logic [BUF_AW:0]   buf_count;
  logic              start;
  logic [ADDR_W-1:0] dest_addr;
  logic [LEN_W-1:0]  pkt_len;
  logic              inject_err;
  logic              tx_ready;
  logic              start_err;
  logic              busy;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_out;
  logic              done;

  modport slave (
    input  wr_en, wr_data, start, dest_addr,
    input  pkt_len, inject_err, busy,
    output buf_full, buf_count, tx_ready,
    output start_err, pkt_valid, data_out, done
  );

  modport master (
    output wr_en, wr_data, start, dest_addr,
    output pkt_len, inject_err, busy,
    input  buf_full, buf_count, tx_ready,
    input  start_err, pkt_valid, data_out, done
  );
endinterface

// File: rtl/router_tx_fifo.sv
// Payload buffer: 64x8 sync FIFO with fall-through head
// and a look-ahead port for the byte behind the head.
import router_pkg::*;

module router_tx_fifo (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [DATA_W-1:0] head_next,
  output logic [BUF_AW:0]   count,
  output logic              full
);
  localparam logic [BUF_AW:0] DEPTH_C =
    (BUF_AW+1)'(1 << BUF_AW);
  localparam logic [BUF_AW-1:0] ONE_P =
    {{(BUF_AW-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [1 << BUF_AW];
  logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_AW:0]   count_q, count_d;
  logic              push, do_pop;

  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign push      = wr_en && !full;
  assign do_pop    = pop && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_q + ONE_P];

  // pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE_P;
    if (do_pop) rd_ptr_d = rd_ptr_q + ONE_P;
    unique case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // pointer/count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array, contents irrelevant until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: header, buffered payload
// and parity byte, holding the current byte while busy.
import router_pkg::*;

module router_pkt_tx (
  input logic            clk,
  input logic            rst,
  router_pkt_tx_if.slave io
);
  localparam logic [LEN_W-1:0] LEN_ONE =
    {{(LEN_W-1){1'b0}}, 1'b1};

  tx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic              inject_q, inject_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              start_err_q, start_err_d;
  logic              tx_ready_q, tx_ready_d;
  logic              done_q, done_d;
  logic              pop, consume, bad_start;
  logic [DATA_W-1:0] head, head_next, par_next;

  router_tx_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (io.wr_en),
    .wr_data   (io.wr_data),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .count     (io.buf_count),
    .full      (io.buf_full)
  );

  assign consume   = !io.busy;
  assign par_next  = parity_q ^ data_out_q;
  assign bad_start = (io.dest_addr == ADDR_INVALID)
                  || (io.pkt_len == '0)
                  || ({1'b0, io.pkt_len} > io.buf_count);

  // next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    parity_d    = parity_q;
    inject_d    = inject_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    start_err_d = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        pkt_valid_d = 1'b0;
        data_out_d  = '0;
        if (io.start && bad_start) begin
          start_err_d = 1'b1;
        end else if (io.start) begin
          state_d     = HEADER;
          len_d       = io.pkt_len;
          inject_d    = io.inject_err;
          pkt_valid_d = 1'b1;
          data_out_d  = make_header(io.pkt_len,
                                    io.dest_addr);
        end
      end
      HEADER: if (consume) begin
        parity_d    = data_out_q;
        remaining_d = len_q;
        state_d     = PAYLOAD;
        data_out_d  = head;
      end
      PAYLOAD: if (consume) begin
        pop         = 1'b1;
        parity_d    = par_next;
        remaining_d = remaining_q - LEN_ONE;
        if (remaining_q == LEN_ONE) begin
          state_d     = PARITY;
          pkt_valid_d = 1'b0;
          data_out_d  = par_next ^
            {{(DATA_W-1){1'b0}}, inject_q};
        end else begin
          data_out_d  = head_next;
        end
      end
      PARITY: if (consume) begin
        state_d    = GAP;
        data_out_d = '0;
      end
      GAP: state_d = IDLE;
      default: begin
        state_d     = IDLE;
        pkt_valid_d = 1'b0;
        data_out_d  = '0;
      end
    endcase
    tx_ready_d = (state_d == IDLE);
    done_d     = (state_d == GAP);
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      remaining_q <= '0;
      parity_q    <= '0;
      inject_q    <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= '0;
      start_err_q <= 1'b0;
      tx_ready_q  <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      parity_q    <= parity_d;
      inject_q    <= inject_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      start_err_q <= start_err_d;
      tx_ready_q  <= tx_ready_d;
      done_q      <= done_d;
    end
  end

  assign io.pkt_valid = pkt_valid_q;
  assign io.data_out  = data_out_q;
  assign io.start_err = start_err_q;
  assign io.tx_ready  = tx_ready_q;
  assign io.done      = done_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: packet framing, stall,
// start rejection, parity injection, full buffer and reset.
module tb_router_pkt_tx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  router_pkt_tx_if io();

  router_pkt_tx dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] cap_d [0:79];
  logic       cap_v [0:79];
  int         cap_n;
  bit         cap_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    io.wr_en   = 1'b1;
    io.wr_data = b;
    tick();
    io.wr_en   = 1'b0;
  endtask

  task automatic send_start(input logic [1:0] a,
                            input logic [5:0] l,
                            input logic inj);
    io.dest_addr  = a;
    io.pkt_len    = l;
    io.inject_err = inj;
    io.start      = 1'b1;
    tick();
    io.start      = 1'b0;
    io.inject_err = 1'b0;
  endtask

  task automatic capture(input int max_cyc);
    cap_n    = 0;
    cap_done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (io.done === 1'b1) begin
        cap_done = 1'b1;
        break;
      end
      if (cap_n < 80) begin
        cap_d[cap_n] = io.data_out;
        cap_v[cap_n] = io.pkt_valid;
      end
      cap_n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({io.tx_ready, io.pkt_valid, io.start_err,
         io.done, io.buf_full} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b want 10000",
        {io.tx_ready, io.pkt_valid, io.start_err,
         io.done, io.buf_full});
    end
    checks++;
    if (io.data_out !== 8'h00 || io.buf_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%0d want 00/0",
        io.data_out, io.buf_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] ed [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    logic       ev [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    checks++;
    if (io.buf_count !== 7'd3) begin
      errors++;
      $display("FAIL basic_count got %0d want 3", io.buf_count);
    end
    send_start(2'd1, 6'd3, 1'b0);
    capture(20);
    checks++;
    if (!cap_done || cap_n != 5) begin
      errors++;
      $display("FAIL basic_len got %0d done=%0d want 5 done=1",
        cap_n, cap_done);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (cap_d[j] !== ed[j] || cap_v[j] !== ev[j]) begin
        errors++;
        $display("FAIL basic_byte%0d got %h/%b want %h/%b",
          j, cap_d[j], cap_v[j], ed[j], ev[j]);
      end
    end
    checks++;
    if (io.buf_count !== 7'd0 || io.pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_after got cnt=%0d v=%b want 0/0",
        io.buf_count, io.pkt_valid);
    end
    tick();
    checks++;
    if (io.tx_ready !== 1'b1 || io.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got rdy=%b done=%b want 1/0",
        io.tx_ready, io.done);
    end
  endtask

  task automatic test_busy();
    logic [7:0] ed [8] = '{8'h0D, 8'h11, 8'h22, 8'h22,
                           8'h22, 8'h33, 8'h0D, 8'h00};
    logic [7:0] got [8];
    logic       gv  [8];
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    send_start(2'd1, 6'd3, 1'b0);
    for (int c = 0; c < 8; c++) begin
      got[c] = io.data_out;
      gv[c]  = io.pkt_valid;
      io.busy = (c == 2 || c == 3);
      tick();
      io.busy = 1'b0;
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (got[j] !== ed[j] || gv[j] !== (j < 6)) begin
        errors++;
        $display("FAIL busy_cyc%0d got %h/%b want %h/%b",
          j, got[j], gv[j], ed[j], (j < 6));
      end
    end
    checks++;
    if (io.tx_ready !== 1'b1 || io.buf_count !== 7'd0) begin
      errors++;
      $display("FAIL busy_end got rdy=%b cnt=%0d want 1/0",
        io.tx_ready, io.buf_count);
    end
  endtask

  task automatic test_start_err();
    logic [1:0] ta [3] = '{2'd3, 2'd1, 2'd1};
    logic [5:0] tl [3] = '{6'd3, 6'd0, 6'd5};
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    for (int k = 0; k < 3; k++) begin
      send_start(ta[k], tl[k], 1'b0);
      checks++;
      if (io.start_err !== 1'b1 || io.pkt_valid !== 1'b0 ||
          io.tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL start_err%0d got e=%b v=%b r=%b want 1/0/1",
          k, io.start_err, io.pkt_valid, io.tx_ready);
      end
      tick();
      checks++;
      if (io.start_err !== 1'b0 || io.pkt_valid !== 1'b0 ||
          io.buf_count !== 7'd3) begin
        errors++;
        $display("FAIL start_err%0d_after got e=%b v=%b c=%0d want 0/0/3",
          k, io.start_err, io.pkt_valid, io.buf_count);
      end
    end
  endtask

  task automatic test_inject();
    send_start(2'd1, 6'd3, 1'b1);
    capture(20);
    checks++;
    if (!cap_done || cap_n != 5 || cap_d[4] !== 8'h0C ||
        cap_v[4] !== 1'b0) begin
      errors++;
      $display("FAIL inject_par got %h n=%0d want 0C n=5",
        cap_d[4], cap_n);
    end
    tick();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    send_start(2'd1, 6'd3, 1'b0);
    capture(20);
    checks++;
    if (!cap_done || cap_n != 5 || cap_d[4] !== 8'h0D) begin
      errors++;
      $display("FAIL inject_clear got %h n=%0d want 0D n=5",
        cap_d[4], cap_n);
    end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 65; i++) write_byte(8'(i));
    checks++;
    if (io.buf_full !== 1'b1 || io.buf_count !== 7'd64) begin
      errors++;
      $display("FAIL full_flag got f=%b c=%0d want 1/64",
        io.buf_full, io.buf_count);
    end
    send_start(2'd0, 6'd63, 1'b0);
    capture(80);
    checks++;
    if (!cap_done || cap_n != 65) begin
      errors++;
      $display("FAIL full_len got %0d want 65", cap_n);
    end
    checks++;
    if (cap_d[0] !== 8'hFC || cap_d[1] !== 8'h00 ||
        cap_d[63] !== 8'd62 || cap_d[64] !== 8'hC3) begin
      errors++;
      $display("FAIL full_bytes got %h %h %h %h want FC 00 3E C3",
        cap_d[0], cap_d[1], cap_d[63], cap_d[64]);
    end
    tick();
    checks++;
    if (io.buf_count !== 7'd1 || io.buf_full !== 1'b0) begin
      errors++;
      $display("FAIL full_after got c=%0d f=%b want 1/0",
        io.buf_count, io.buf_full);
    end
  endtask

  task automatic test_reset_mid();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    send_start(2'd2, 6'd3, 1'b0);
    tick();
    tick();
    checks++;
    if (io.pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got v=%b want 1", io.pkt_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (io.pkt_valid !== 1'b0 || io.buf_count !== 7'd0 ||
        io.tx_ready !== 1'b1 || io.data_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst got v=%b c=%0d r=%b d=%h want 0/0/1/00",
        io.pkt_valid, io.buf_count, io.tx_ready, io.data_out);
    end
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (io.pkt_valid !== 1'b0 || io.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_post got v=%b r=%b want 0/1",
        io.pkt_valid, io.tx_ready);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    io.wr_en      = 1'b0;
    io.wr_data    = '0;
    io.start      = 1'b0;
    io.dest_addr  = '0;
    io.pkt_len    = '0;
    io.inject_err = 1'b0;
    io.busy       = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_start_err();
    test_inject();
    test_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
